// File: rtl/synth_pkg.sv
// Shared FM synth core definitions: voice/operator geometry, sample width and
// the voice-operator ID type used by the mixer and its upstream stages.
package synth_pkg;

  localparam int NUM_VOICES              = 32;
  localparam int NUM_OPERATORS           = 8;
  localparam int VOICE_OPERATOR_ID_WIDTH = 8;
  localparam int SAMPLE_WIDTH            = 16;

  // {op[2:0], voice[4:0]}
  typedef logic [VOICE_OPERATOR_ID_WIDTH-1:0] voiceOperatorId_t;

  localparam voiceOperatorId_t FRAME_END_ID = voiceOperatorId_t'(NUM_VOICES * NUM_OPERATORS - 1);

  function automatic voiceOperatorId_t nextId(input voiceOperatorId_t id);
    return id + voiceOperatorId_t'(1);
  endfunction

endpackage

// File: rtl/sample_limiter.sv
// Reduces a scaled frame sum to a 16-bit sample and flags out-of-range values.
// SAMPLE_MIXER_SATURATE_EN selects clamping; otherwise the sample wraps.
module sample_limiter
  import synth_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic signed [ACC_WIDTH-1:0]    scaled,
  output logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           clipped
);

  function automatic logic fitsSample(input logic signed [ACC_WIDTH-1:0] value);
    // Fits when every bit from the sample sign bit upward matches.
    return (&value[ACC_WIDTH-1:SAMPLE_WIDTH-1]) || !(|value[ACC_WIDTH-1:SAMPLE_WIDTH-1]);
  endfunction

  function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] value);
    logic signed [SAMPLE_WIDTH-1:0] result;
    if (fitsSample(value))
      result = value[SAMPLE_WIDTH-1:0];
    else if (value[ACC_WIDTH-1])
      result = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    else
      result = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    return result;
  endfunction

  always_comb begin
    clipped = !fitsSample(scaled);
`ifdef SAMPLE_MIXER_SATURATE_EN
    sample  = saturate(scaled);
`else
    sample  = scaled[SAMPLE_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/sample_mixer.sv
// Final FM synth stage: sums carrier operators over a 256-slot frame, scales
// and limits the sum into one audio sample per clean frame (see sample_limiter
// for the SAMPLE_MIXER_SATURATE_EN option).
module sample_mixer
  import synth_pkg::*;
#(
  parameter int OUTPUT_SHIFT = 5,
  parameter int ACC_WIDTH    = 24
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Valid,
  input  logic [7:0]         i_VoiceOperator,
  input  logic               i_Carrier,
  input  logic signed [15:0] i_OperatorOutput,
  output logic               o_SampleReady,
  output logic signed [15:0] o_Sample,
  output logic               o_Clipped,
  output logic               o_SyncError
);

  logic signed [ACC_WIDTH-1:0]    r_Acc;
  voiceOperatorId_t               r_Expected;
  logic                           r_Dirty;

  logic signed [ACC_WIDTH-1:0]    term;
  logic signed [ACC_WIDTH-1:0]    finalSum;
  logic signed [ACC_WIDTH-1:0]    scaled;
  logic signed [SAMPLE_WIDTH-1:0] limitedSample;
  logic                           limitedClipped;
  logic                           inOrder;
  logic                           frameEnd;

  always_comb begin
    term     = i_Carrier ? {{(ACC_WIDTH-SAMPLE_WIDTH){i_OperatorOutput[SAMPLE_WIDTH-1]}}, i_OperatorOutput}
                         : '0;
    finalSum = r_Acc + term;
    scaled   = finalSum >>> OUTPUT_SHIFT;
    inOrder  = (i_VoiceOperator == r_Expected);
    frameEnd = (i_VoiceOperator == FRAME_END_ID);
  end

  sample_limiter #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_limiter (
    .scaled (scaled),
    .sample (limitedSample),
    .clipped(limitedClipped)
  );

  // Accumulate stage: frame sum, order tracking and registered sample output
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Acc         <= '0;
      r_Expected    <= '0;
      r_Dirty       <= 1'b0;
      o_SampleReady <= 1'b0;
      o_Sample      <= '0;
      o_Clipped     <= 1'b0;
      o_SyncError   <= 1'b0;
    end else begin
      o_SampleReady <= 1'b0;
      if (i_Valid) begin
        // Resynchronise on the received ID whether or not it was expected.
        r_Expected <= nextId(i_VoiceOperator);
        if (!inOrder) begin
          o_SyncError <= 1'b1;
          if (frameEnd) begin
            r_Acc   <= '0;
            r_Dirty <= 1'b0;
          end else begin
            r_Acc   <= term;
            r_Dirty <= 1'b1;
          end
        end else if (frameEnd) begin
          r_Acc   <= '0;
          r_Dirty <= 1'b0;
          if (!r_Dirty) begin
            o_Sample      <= limitedSample;
            o_Clipped     <= limitedClipped;
            o_SampleReady <= 1'b1;
          end
        end else begin
          r_Acc <= finalSum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_mixer.sv
// Directed self-checking bench for sample_mixer (expectations follow
// SAMPLE_MIXER_SATURATE_EN when the build defines it).
module tb_sample_mixer;

  logic               i_Clock = 1'b0;
  logic               i_Reset = 1'b1;
  logic               i_Valid = 1'b0;
  logic [7:0]         i_VoiceOperator = 8'h00;
  logic               i_Carrier = 1'b0;
  logic signed [15:0] i_OperatorOutput = 16'sd0;
  logic               o_SampleReady;
  logic signed [15:0] o_Sample;
  logic               o_Clipped;
  logic               o_SyncError;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 i_Clock = ~i_Clock;

  sample_mixer #(
    .OUTPUT_SHIFT(5),
    .ACC_WIDTH   (24)
  ) dut (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Valid         (i_Valid),
    .i_VoiceOperator (i_VoiceOperator),
    .i_Carrier       (i_Carrier),
    .i_OperatorOutput(i_OperatorOutput),
    .o_SampleReady   (o_SampleReady),
    .o_Sample        (o_Sample),
    .o_Clipped       (o_Clipped),
    .o_SyncError     (o_SyncError)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock with the given input; outputs are sampled 1 time unit after the edge.
  task automatic sendOp(input logic [7:0] id, input logic carrier, input logic [15:0] value);
    i_Valid          = 1'b1;
    i_VoiceOperator  = id;
    i_Carrier        = carrier;
    i_OperatorOutput = value;
    @(posedge i_Clock);
    #1;
    if (o_SampleReady) pulses++;
    i_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      i_Valid = 1'b0;
      @(posedge i_Clock);
      #1;
      if (o_SampleReady) pulses++;
    end
  endtask

  // Sends IDs 0x00..0xFE; op 0 slots (IDs < 32) carry carrierVal unless allCarriers.
  task automatic sendBody(input logic allCarriers, input logic [15:0] carrierVal, input logic [15:0] otherVal);
    for (int id = 0; id < 255; id++) begin
      if (allCarriers || id < 32) sendOp(8'(id), 1'b1, carrierVal);
      else                        sendOp(8'(id), 1'b0, otherVal);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge i_Clock);
    #1;
    check("reset_sample", 32'(o_Sample), 32'h0);
    check("reset_ready", 32'(o_SampleReady), 32'h0);
    check("reset_clipped", 32'(o_Clipped), 32'h0);
    check("reset_syncerr", 32'(o_SyncError), 32'h0);
    i_Reset = 1'b0;

    // Clean frame: 32 carriers of 100 -> 3200 >>> 5 = 100
    pulses = 0;
    sendBody(1'b0, 16'd100, 16'd5000);
    check("clean_early_pulse", 32'(pulses), 32'h0);
    sendOp(8'hFF, 1'b0, 16'd5000);
    check("clean_ready", 32'(o_SampleReady), 32'h1);
    check("clean_sample", 32'(o_Sample), 32'h0000_0064);
    check("clean_clipped", 32'(o_Clipped), 32'h0);
    idle(1);
    check("clean_pulse_width", 32'(o_SampleReady), 32'h0);
    check("clean_hold", 32'(o_Sample), 32'h0000_0064);

    // All 256 carriers at +32767 -> scaled 262136
    sendBody(1'b1, 16'h7FFF, 16'h0);
    sendOp(8'hFF, 1'b1, 16'h7FFF);
    check("pos_ready", 32'(o_SampleReady), 32'h1);
`ifdef SAMPLE_MIXER_SATURATE_EN
    check("pos_sample", 32'({16'h0, o_Sample}), 32'h0000_7FFF);
`else
    check("pos_sample", 32'({16'h0, o_Sample}), 32'h0000_FFF8);
`endif
    check("pos_clipped", 32'(o_Clipped), 32'h1);

    // All 256 carriers at -32768 -> sum -8388608, scaled -262144
    sendBody(1'b1, 16'h8000, 16'h0);
    sendOp(8'hFF, 1'b1, 16'h8000);
    check("neg_ready", 32'(o_SampleReady), 32'h1);
`ifdef SAMPLE_MIXER_SATURATE_EN
    check("neg_sample", 32'({16'h0, o_Sample}), 32'h0000_8000);
`else
    check("neg_sample", 32'({16'h0, o_Sample}), 32'h0000_0000);
`endif
    check("neg_clipped", 32'(o_Clipped), 32'h1);

    // Valid gap of 10 cycles mid-frame; op 0 carriers of 64 -> 2048 >>> 5 = 64
    pulses = 0;
    for (int id = 0; id < 255; id++) begin
      if (id == 8'h80) idle(10);
      sendOp(8'(id), id < 32, (id < 32) ? 16'd64 : 16'd7000);
    end
    check("gap_early_pulse", 32'(pulses), 32'h0);
    sendOp(8'hFF, 1'b0, 16'd7000);
    check("gap_ready", 32'(o_SampleReady), 32'h1);
    check("gap_sample", 32'(o_Sample), 32'h0000_0040);
    check("gap_clipped", 32'(o_Clipped), 32'h0);
    check("gap_syncerr", 32'(o_SyncError), 32'h0);

    // Skip ID 0x40: dirty frame yields no sample, then a clean frame of 32s
    pulses = 0;
    for (int id = 0; id < 256; id++) begin
      if (id != 8'h40) sendOp(8'(id), id < 32, 16'd500);
    end
    check("skip_syncerr", 32'(o_SyncError), 32'h1);
    check("skip_no_pulse", 32'(pulses), 32'h0);
    check("skip_sample_held", 32'(o_Sample), 32'h0000_0040);
    sendBody(1'b0, 16'd32, 16'd9000);
    sendOp(8'hFF, 1'b0, 16'd9000);
    check("resync_ready", 32'(o_SampleReady), 32'h1);
    check("resync_sample", 32'(o_Sample), 32'h0000_0020);
    check("resync_syncerr_sticky", 32'(o_SyncError), 32'h1);

    // Reset at ID 0x80 with a nonzero partial sum
    for (int id = 0; id < 128; id++) sendOp(8'(id), 1'b1, 16'd1000);
    i_Reset = 1'b1;
    sendOp(8'h80, 1'b1, 16'd1000);
    check("rst_sample", 32'(o_Sample), 32'h0);
    check("rst_ready", 32'(o_SampleReady), 32'h0);
    check("rst_clipped", 32'(o_Clipped), 32'h0);
    check("rst_syncerr", 32'(o_SyncError), 32'h0);
    i_Reset = 1'b0;
    pulses = 0;
    sendBody(1'b1, 16'd0, 16'd0);
    sendOp(8'hFF, 1'b1, 16'd0);
    check("post_rst_ready", 32'(o_SampleReady), 32'h1);
    check("post_rst_sample", 32'(o_Sample), 32'h0);
    check("post_rst_syncerr", 32'(o_SyncError), 32'h0);
    check("post_rst_pulses", 32'(pulses), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
